// File: rtl/rom_dl_arbiter.sv
// rtl/rom_dl_arbiter.sv - single-port ROM owner arbitrating HPS download writes against core reads
// Optional download checksum enabled by defining ROM_DL_ARB_CKSUM_EN.
module rom_dl_arbiter #(
    parameter int AW       = 16,
    parameter int FIFO_DEP = 4,
    parameter int HOLD_CYC = 16,
    parameter int MEM_LAT  = 1
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic          DL_ACT,
    input  logic          DL_WE,
    input  logic [AW-1:0] DL_AD,
    input  logic [7:0]    DL_DT,
    input  logic          RD_REQ,
    input  logic [AW-1:0] RD_AD,
    output logic          RD_ACK,
    output logic [7:0]    RD_DT,
    output logic [AW-1:0] MEM_AD,
    output logic [7:0]    MEM_DO,
    output logic          MEM_WE,
    input  logic [7:0]    MEM_DI,
    output logic          CORE_RST,
    output logic          DL_DONE,
    output logic          FIFO_OVF,
    output logic [7:0]    CKSUM
);

    localparam int PW = $clog2(FIFO_DEP);
    localparam int CW = $clog2(HOLD_CYC + 1);
    localparam int EW = AW + 8;
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEP);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYC);
    localparam logic [1:0]    LAT_INIT  = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_DL, S_RD, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    lat_cnt_q, lat_cnt_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          rd_ack_q, rd_ack_d;
    logic [7:0]    rd_dt_q, rd_dt_d;
    logic [AW-1:0] mem_ad_q, mem_ad_d;
    logic [7:0]    mem_do_q, mem_do_d;
    logic          mem_we_q, mem_we_d;
    logic          core_rst_q, core_rst_d;
    logic          dl_done_q, dl_done_d;
    logic          ovf_q, ovf_d;

    logic [EW-1:0] fifo_mem [FIFO_DEP];
    logic [EW-1:0] head;
    logic          fifo_empty, fifo_full, avail;
    logic          pop, pop_mem, bypass, push;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // An empty FIFO forwards the incoming byte so a lone write costs no extra cycle.
        avail      = !fifo_empty || DL_WE;
        head       = fifo_empty ? {DL_AD, DL_DT} : fifo_mem[rptr_q];

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        rd_ack_d   = 1'b0;
        rd_dt_d    = rd_dt_q;
        mem_ad_d   = mem_ad_q;
        mem_do_d   = mem_do_q;
        mem_we_d   = 1'b0;
        dl_done_d  = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    pop = 1'b1;
                end else if (RD_REQ && !DL_ACT && !rd_ack_q) begin
                    state_d   = S_RD;
                    mem_ad_d  = RD_AD;
                    lat_cnt_d = LAT_INIT;
                end else if (DL_ACT) begin
                    state_d = S_DL;
                end
            end
            S_WR, S_DL: begin
                if (avail) begin
                    pop = 1'b1;
                end else if (DL_ACT) begin
                    state_d = S_DL;
                end else begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            S_RD: begin
                if (lat_cnt_q == 2'd0) begin
                    rd_ack_d = 1'b1;
                    rd_dt_d  = MEM_DI;
                    state_d  = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            S_HOLD: begin
                if (avail) begin
                    pop = 1'b1;
                end else if (DL_ACT) begin
                    state_d = S_DL;
                end else if (hold_cnt_q <= CW'(1)) begin
                    dl_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end
            default: state_d = S_HOLD;
        endcase

        if (pop) begin
            state_d              = S_WR;
            mem_we_d             = 1'b1;
            {mem_ad_d, mem_do_d} = head;
        end

        core_rst_d = (state_d == S_WR) || (state_d == S_DL) || (state_d == S_HOLD);

        pop_mem = pop && !fifo_empty;
        bypass  = pop && fifo_empty;
        push    = DL_WE && !bypass && (!fifo_full || pop_mem);
        ovf_d   = ovf_q || (DL_WE && !bypass && !push);
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop_mem ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop_mem);
    end

    always_ff @(posedge MCLK) begin
        if (push) fifo_mem[wptr_q] <= {DL_AD, DL_DT};
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HOLD_INIT;
            lat_cnt_q  <= 2'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_ack_q   <= 1'b0;
            rd_dt_q    <= 8'h00;
            mem_ad_q   <= '0;
            mem_do_q   <= 8'h00;
            mem_we_q   <= 1'b0;
            core_rst_q <= 1'b1;
            dl_done_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_ack_q   <= rd_ack_d;
            rd_dt_q    <= rd_dt_d;
            mem_ad_q   <= mem_ad_d;
            mem_do_q   <= mem_do_d;
            mem_we_q   <= mem_we_d;
            core_rst_q <= core_rst_d;
            dl_done_q  <= dl_done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef ROM_DL_ARB_CKSUM_EN
    logic       dl_act_q;
    logic [7:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (DL_ACT && !dl_act_q) cksum_d = 8'h00;
        if (pop) cksum_d = cksum_d + head[7:0];
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_act_q <= 1'b0;
            cksum_q  <= 8'h00;
        end else begin
            dl_act_q <= DL_ACT;
            cksum_q  <= cksum_d;
        end
    end

    assign CKSUM = cksum_q;
`else
    assign CKSUM = 8'h00;
`endif

    assign RD_ACK   = rd_ack_q;
    assign RD_DT    = rd_dt_q;
    assign MEM_AD   = mem_ad_q;
    assign MEM_DO   = mem_do_q;
    assign MEM_WE   = mem_we_q;
    assign CORE_RST = core_rst_q;
    assign DL_DONE  = dl_done_q;
    assign FIFO_OVF = ovf_q;

endmodule
